// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric: bridges the picorv32 native memory port to NSLAVES
// memory-mapped targets. One registered transaction at a time, with
// unmapped-address errors, a per-access watchdog and error bookkeeping.
`timescale 1ns/1ps

module cpu_bus_fabric #(
  parameter int                    NSLAVES       = 4,
  parameter logic [NSLAVES*32-1:0] SLV_BASE      = {32'h0003_0000, 32'h0002_0000,
                                                    32'h0001_0000, 32'h0000_0000},
  parameter logic [NSLAVES*32-1:0] SLV_MASK      = {4{32'hFFFF_0000}},
  parameter int                    TIMEOUT       = 255,
  parameter logic [31:0]           DEFAULT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  // CPU side
  input  logic                  cpu_mem_op,
  output logic                  cpu_mem_rdy,
  input  logic [31:0]           cpu_adr,
  input  logic [31:0]           cpu_do,
  input  logic [3:0]            cpu_wren,
  output logic [31:0]           cpu_di,
  // Slave side
  output logic [NSLAVES-1:0]    slv_op,
  input  logic [NSLAVES-1:0]    slv_rdy,
  output logic [31:0]           slv_adr,
  output logic [31:0]           slv_do,
  output logic [3:0]            slv_wren,
  input  logic [NSLAVES*32-1:0] slv_di,
  // Error reporting
  output logic                  bus_err,
  output logic [31:0]           err_adr,
  output logic [15:0]           err_count
);

  localparam int            SW      = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // S_DECERR is the unmapped-access counterpart of S_ACCESS: it keeps mapped
  // and unmapped accesses on the same 2-cycle request-to-ready latency.
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DECERR,
    S_RESP
  } state_e;

  state_e              state_q;
  logic [NSLAVES-1:0]  slv_op_q;
  logic [SW-1:0]       sel_q;
  logic [CW-1:0]       wd_q;
  logic [31:0]         adr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wren_q;
  logic [31:0]         rdata_q;
  logic                rdy_q;
  logic                err_q;
  logic [31:0]         err_adr_q;
  logic [15:0]         err_count_q;

  logic                hit;
  logic [SW-1:0]       hit_idx;
  logic                sel_rdy;
  logic [31:0]         sel_rdata;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if ((cpu_adr & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]) begin
        hit     = 1'b1;
        hit_idx = SW'(k);
      end
    end
  end

  // Only the selected slave's ready and read data are ever looked at.
  assign sel_rdy   = slv_rdy[sel_q];
  assign sel_rdata = slv_di[32*int'(sel_q) +: 32];

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      slv_op_q    <= '0;
      sel_q       <= '0;
      wd_q        <= '0;
      adr_q       <= '0;
      wdata_q     <= '0;
      wren_q      <= '0;
      rdata_q     <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      err_adr_q   <= '0;
      err_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge register values and the defaults below are simply overridden.
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cpu_mem_op) begin
            adr_q   <= cpu_adr;
            wdata_q <= cpu_do;
            wren_q  <= cpu_wren;
            if (hit) begin
              sel_q    <= hit_idx;
              slv_op_q <= NSLAVES'(1) << hit_idx;
              wd_q     <= '0;
              state_q  <= S_ACCESS;
            end else begin
              rdata_q   <= DEFAULT_RDATA;
              err_q     <= 1'b1;
              err_adr_q <= cpu_adr;
              if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
              state_q   <= S_DECERR;
            end
          end
        end
        S_ACCESS: begin
          if (sel_rdy) begin
            rdata_q  <= sel_rdata;
            slv_op_q <= '0;
            rdy_q    <= 1'b1;
            state_q  <= S_RESP;
          end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
            rdata_q   <= DEFAULT_RDATA;
            slv_op_q  <= '0;
            rdy_q     <= 1'b1;
            err_q     <= 1'b1;
            err_adr_q <= adr_q;
            if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
            state_q   <= S_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DECERR: begin
          rdy_q   <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_mem_rdy = rdy_q;
  assign cpu_di      = rdata_q;
  assign slv_op      = slv_op_q;
  assign slv_adr     = adr_q;
  assign slv_do      = wdata_q;
  assign slv_wren    = wren_q;
  assign bus_err     = err_q;
  assign err_adr     = err_adr_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Directed self-checking bench for cpu_bus_fabric (default parameters).
`timescale 1ns/1ps

module tb_cpu_bus_fabric;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cpu_mem_op = 1'b0;
  logic         cpu_mem_rdy;
  logic [31:0]  cpu_adr = '0;
  logic [31:0]  cpu_do = '0;
  logic [3:0]   cpu_wren = '0;
  logic [31:0]  cpu_di;
  logic [3:0]   slv_op;
  logic [3:0]   slv_rdy = '0;
  logic [31:0]  slv_adr;
  logic [31:0]  slv_do;
  logic [3:0]   slv_wren;
  logic [127:0] slv_di = '0;
  logic         bus_err;
  logic [31:0]  err_adr;
  logic [15:0]  err_count;

  int tests_run = 0;
  int tests_failed = 0;

  cpu_bus_fabric dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_mem_op (cpu_mem_op),
    .cpu_mem_rdy(cpu_mem_rdy),
    .cpu_adr    (cpu_adr),
    .cpu_do     (cpu_do),
    .cpu_wren   (cpu_wren),
    .cpu_di     (cpu_di),
    .slv_op     (slv_op),
    .slv_rdy    (slv_rdy),
    .slv_adr    (slv_adr),
    .slv_do     (slv_do),
    .slv_wren   (slv_wren),
    .slv_di     (slv_di),
    .bus_err    (bus_err),
    .err_adr    (err_adr),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    tests_run++;
    if ({cpu_mem_rdy, bus_err, slv_op} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rdy/err/op=%b expected 000000", {cpu_mem_rdy, bus_err, slv_op});
    end
    tests_run++;
    if ({cpu_di, slv_adr, slv_do, err_adr} !== 128'b0) begin
      tests_failed++;
      $display("FAIL reset_data: di=%h adr=%h do=%h eadr=%h expected all 0",
               cpu_di, slv_adr, slv_do, err_adr);
    end
    tests_run++;
    if ({slv_wren, err_count} !== 20'b0) begin
      tests_failed++;
      $display("FAIL reset_cnt: wren=%h cnt=%h expected 0", slv_wren, err_count);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_hit();
    cpu_adr = 32'h0000_0010; cpu_wren = 4'b0000; cpu_mem_op = 1'b1;
    slv_di[31:0] = 32'h1234_5678;
    step();
    tests_run++;
    if (slv_op !== 4'b0001 || slv_adr !== 32'h10 || cpu_mem_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_access: op=%b adr=%h rdy=%b expected 0001 00000010 0",
               slv_op, slv_adr, cpu_mem_rdy);
    end
    slv_rdy = 4'b0001;
    step();
    slv_rdy = 4'b0000;
    cpu_mem_op = 1'b0;
    tests_run++;
    if (cpu_mem_rdy !== 1'b1 || slv_op !== 4'b0000 || cpu_di !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL read_resp: rdy=%b op=%b di=%h expected 1 0000 12345678",
               cpu_mem_rdy, slv_op, cpu_di);
    end
    step();
    tests_run++;
    if (cpu_mem_rdy !== 1'b0 || cpu_di !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL read_idle: rdy=%b di=%h expected 0 12345678", cpu_mem_rdy, cpu_di);
    end
  endtask

  task automatic test_write_stall();
    int bad = 0;
    cpu_adr = 32'h0002_0004; cpu_do = 32'hA5A5_A5A5; cpu_wren = 4'b0011; cpu_mem_op = 1'b1;
    slv_di[95:64] = 32'h0BAD_0BAD;
    step();
    // Five stall cycles with the unselected slaves claiming ready.
    for (int i = 0; i < 5; i++) begin
      if (slv_op !== 4'b0100 || slv_adr !== 32'h0002_0004 || slv_do !== 32'hA5A5_A5A5 ||
          slv_wren !== 4'b0011 || cpu_mem_rdy !== 1'b0) bad++;
      slv_rdy = 4'b1011;
      step();
    end
    tests_run++;
    if (bad != 0 || slv_op !== 4'b0100) begin
      tests_failed++;
      $display("FAIL write_stall: %0d unstable cycles, op=%b expected 0 cycles and 0100", bad, slv_op);
    end
    slv_rdy = 4'b0100;
    step();
    slv_rdy = 4'b0000;
    cpu_mem_op = 1'b0;
    tests_run++;
    if (cpu_mem_rdy !== 1'b1 || slv_op !== 4'b0000 || bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_resp: rdy=%b op=%b err=%b expected 1 0000 0", cpu_mem_rdy, slv_op, bus_err);
    end
    step();
    tests_run++;
    if (cpu_mem_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_pulse: rdy=%b expected 0", cpu_mem_rdy);
    end
  endtask

  // One unmapped access, checking the 2-cycle error response.
  task automatic do_unmapped(input logic [31:0] adr, input logic [15:0] exp_cnt);
    cpu_adr = adr; cpu_wren = 4'b0000; cpu_mem_op = 1'b1;
    step();
    tests_run++;
    if (bus_err !== 1'b1 || err_adr !== adr || cpu_mem_rdy !== 1'b0 || slv_op !== 4'b0000) begin
      tests_failed++;
      $display("FAIL unmapped_err: err=%b eadr=%h rdy=%b op=%b expected 1 %h 0 0000",
               bus_err, err_adr, cpu_mem_rdy, slv_op, adr);
    end
    step();
    cpu_mem_op = 1'b0;
    tests_run++;
    if (cpu_mem_rdy !== 1'b1 || cpu_di !== 32'hDEAD_BEEF || bus_err !== 1'b0 ||
        err_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL unmapped_resp: rdy=%b di=%h err=%b cnt=%h expected 1 deadbeef 0 %h",
               cpu_mem_rdy, cpu_di, bus_err, err_count, exp_cnt);
    end
    step();
  endtask

  task automatic test_unmapped();
    do_unmapped(32'h9000_0000, 16'd1);
  endtask

  task automatic test_timeout();
    int n = 0;
    cpu_adr = 32'h0001_0000; cpu_wren = 4'b0000; cpu_mem_op = 1'b1; slv_rdy = 4'b0000;
    step();
    while (slv_op === 4'b0010 && n < 300) begin
      n++;
      step();
    end
    cpu_mem_op = 1'b0;
    tests_run++;
    if (n != 255) begin
      tests_failed++;
      $display("FAIL timeout_len: slv_op high %0d cycles expected 255", n);
    end
    tests_run++;
    if (cpu_mem_rdy !== 1'b1 || bus_err !== 1'b1 || cpu_di !== 32'hDEAD_BEEF ||
        err_adr !== 32'h0001_0000 || err_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL timeout_resp: rdy=%b err=%b di=%h eadr=%h cnt=%h expected 1 1 deadbeef 00010000 0002",
               cpu_mem_rdy, bus_err, cpu_di, err_adr, err_count);
    end
    step();
  endtask

  task automatic test_timeout_ready_last();
    cpu_adr = 32'h0001_0040; cpu_wren = 4'b0000; cpu_mem_op = 1'b1;
    slv_di[63:32] = 32'hCAFE_F00D;
    step();
    for (int i = 0; i < 254; i++) step();
    tests_run++;
    if (slv_op !== 4'b0010) begin
      tests_failed++;
      $display("FAIL last_cycle_op: op=%b expected 0010", slv_op);
    end
    slv_rdy = 4'b0010;
    step();
    slv_rdy = 4'b0000;
    cpu_mem_op = 1'b0;
    tests_run++;
    if (cpu_mem_rdy !== 1'b1 || bus_err !== 1'b0 || cpu_di !== 32'hCAFE_F00D || err_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL last_cycle_ready: rdy=%b err=%b di=%h cnt=%h expected 1 0 cafef00d 0002",
               cpu_mem_rdy, bus_err, cpu_di, err_count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    cpu_adr = 32'h0003_0008; cpu_wren = 4'b0000; cpu_mem_op = 1'b1;
    slv_di[127:96] = 32'h3333_3333;
    slv_di[31:0]   = 32'h4444_4444;
    slv_rdy = 4'b1001;
    step();
    step();
    tests_run++;
    if (cpu_mem_rdy !== 1'b1 || cpu_di !== 32'h3333_3333) begin
      tests_failed++;
      $display("FAIL b2b_first: rdy=%b di=%h expected 1 33333333", cpu_mem_rdy, cpu_di);
    end
    cpu_adr = 32'h0000_0020;
    step();
    tests_run++;
    if (cpu_mem_rdy !== 1'b0 || slv_op !== 4'b0000) begin
      tests_failed++;
      $display("FAIL b2b_gap: rdy=%b op=%b expected 0 0000", cpu_mem_rdy, slv_op);
    end
    step();
    tests_run++;
    if (slv_op !== 4'b0001 || slv_adr !== 32'h0000_0020) begin
      tests_failed++;
      $display("FAIL b2b_second_op: op=%b adr=%h expected 0001 00000020", slv_op, slv_adr);
    end
    step();
    cpu_mem_op = 1'b0;
    slv_rdy = 4'b0000;
    tests_run++;
    if (cpu_mem_rdy !== 1'b1 || cpu_di !== 32'h4444_4444) begin
      tests_failed++;
      $display("FAIL b2b_second: rdy=%b di=%h expected 1 44444444", cpu_mem_rdy, cpu_di);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    cpu_adr = 32'h0002_0100; cpu_wren = 4'b0000; cpu_mem_op = 1'b1;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    tests_run++;
    if (slv_op !== 4'b0000 || cpu_mem_rdy !== 1'b0 || err_count !== 16'd0 || slv_adr !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_async: op=%b rdy=%b cnt=%h adr=%h expected 0000 0 0000 0",
               slv_op, cpu_mem_rdy, err_count, slv_adr);
    end
    cpu_mem_op = 1'b0;
    step();
    reset = 1'b0;
    step();
    cpu_adr = 32'h0000_0004; cpu_mem_op = 1'b1;
    slv_di[31:0] = 32'h0BAD_F00D;
    slv_rdy = 4'b0001;
    step();
    tests_run++;
    if (slv_op !== 4'b0001) begin
      tests_failed++;
      $display("FAIL post_reset_op: op=%b expected 0001", slv_op);
    end
    step();
    cpu_mem_op = 1'b0;
    slv_rdy = 4'b0000;
    tests_run++;
    if (cpu_mem_rdy !== 1'b1 || cpu_di !== 32'h0BAD_F00D) begin
      tests_failed++;
      $display("FAIL post_reset_read: rdy=%b di=%h expected 1 0badf00d", cpu_mem_rdy, cpu_di);
    end
    step();
  endtask

  // Walking the counter up through 65536 real accesses would take ~200k
  // cycles, so it is preset to just below full scale instead.
  task automatic test_err_saturation();
    force dut.err_count_q = 16'hFFFD;
    #1;
    release dut.err_count_q;
    #1;
    do_unmapped(32'h8000_0000, 16'hFFFE);
    do_unmapped(32'h8000_0004, 16'hFFFF);
    do_unmapped(32'hFFFF_FFF0, 16'hFFFF);
    tests_run++;
    if (err_adr !== 32'hFFFF_FFF0) begin
      tests_failed++;
      $display("FAIL sat_err_adr: eadr=%h expected fffffff0", err_adr);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_stall();
    test_unmapped();
    test_timeout();
    test_timeout_ready_last();
    test_back_to_back();
    test_reset_mid_access();
    test_err_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_bus_fabric.md
Name: cpu_bus_fabric

Overview:
- Parametrised successor to the single-target CPU memory-bus hookup.
- Sits between the picorv32 native memory port (mem_valid/mem_ready handshake) and NSLAVES memory-mapped targets (RAM, ROM, peripherals).
- Decodes the address, forwards one registered transaction at a time to the selected slave, and returns its read data.
- Adds what the direct hookup lacks: unmapped-address error responses, a per-access timeout watchdog, and error bookkeeping.

Parameters:
- NSLAVES, 4, number of slave channels (1..8).
- SLV_BASE, {32'h30000,32'h20000,32'h10000,32'h00000}, packed NSLAVES×32 base addresses; slot k is bits [32k+31:32k].
- SLV_MASK, {4{32'hFFFF0000}}, packed NSLAVES×32 decode masks.
- TIMEOUT, 255, max cycles a slave may stall before abort; 0 disables the watchdog.
- DEFAULT_RDATA, 32'hDEADBEEF, read data returned on error or timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_mem_op  in  1  CPU request valid
- cpu_mem_rdy  out  1  one-cycle completion pulse to CPU
- cpu_adr  in  32  CPU byte address
- cpu_do  in  32  CPU write data
- cpu_wren  in  4  CPU byte write strobes; 0 = read
- cpu_di  out  32  read data to CPU
- slv_op  out  NSLAVES  per-slave request valid, one-hot or zero
- slv_rdy  in  NSLAVES  per-slave completion
- slv_adr  out  32  shared registered address
- slv_do  out  32  shared registered write data
- slv_wren  out  4  shared registered strobes
- slv_di  in  NSLAVES×32  per-slave read data, packed
- bus_err  out  1  one-cycle pulse on unmapped access or timeout
- err_adr  out  32  address of the most recent error
- err_count  out  16  saturating error counter

Behaviour:
- Reset: asynchronous and active-high; takes effect immediately, including mid-transaction. All outputs go to 0: cpu_mem_rdy, cpu_di, slv_op, slv_adr, slv_do, slv_wren, bus_err, err_adr, err_count. FSM enters IDLE; watchdog counter clears.
- Address decode: slave k hits when (cpu_adr & SLV_MASK[k]) == SLV_BASE[k]. When regions overlap, the lowest index wins.
- IDLE:
  - On cpu_mem_op=1, register cpu_adr, cpu_do and cpu_wren into slv_adr, slv_do and slv_wren.
  - On a hit, go to ACCESS with slv_op[k]=1 from the next cycle.
  - On a miss, go to RESP with cpu_di=DEFAULT_RDATA, pulse bus_err, and load err_adr.
- ACCESS:
  - Hold slv_op[k] and the registered address/data/strobes stable.
  - The watchdog counter increments each cycle.
  - When slv_rdy[k]=1 (including the first ACCESS cycle), capture slv_di[k] into cpu_di, clear slv_op, and go to RESP.
  - Only slv_rdy of the selected slave is honoured; others are ignored.
- Timeout: TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no slv_rdy:
  - clear slv_op, cpu_di=DEFAULT_RDATA, pulse bus_err, load err_adr, go to RESP;
  - slv_rdy asserted on that same cycle wins over the timeout.
- RESP: cpu_mem_rdy=1 for exactly one cycle, then IDLE. cpu_mem_op is not sampled in RESP. cpu_di holds its value until the next capture.
- Latency: minimum 2 cycles from cpu_mem_op sampled to cpu_mem_rdy (slave ready in its first ACCESS cycle); unmapped access also takes 2 cycles.
- Writes: cpu_di on a write is don't-care, but the same capture rules apply.
- err_count: +1 per bus_err, saturates at 16'hFFFF.
- Back-to-back requests: a new request is accepted in the IDLE cycle after RESP, giving a 3-cycle minimum per transaction.
- Watchdog counter: width $clog2(TIMEOUT+1), cleared on entry to ACCESS.

Test Plan:
- Read 0x00000010, slave0 asserts slv_rdy in its first ACCESS cycle with slv_di0=0x12345678 -> slv_op=4'b0001 for 1 cycle; cpu_mem_rdy 2 cycles after request; cpu_di=0x12345678.
- Write 0x20004 with wren=4'b0011, data 0xA5A5A5A5, slave2 stalls 5 cycles -> slv_op[2] high 6 cycles; slv_adr/slv_do/slv_wren stable throughout; single cpu_mem_rdy pulse.
- Access 0x90000000 (unmapped) -> cpu_mem_rdy after 2 cycles; cpu_di=0xDEADBEEF; bus_err pulse; err_adr=0x90000000; err_count=1.
- Slave1 never ready, TIMEOUT=255 -> slv_op[1] drops after 255 ACCESS cycles; cpu_di=0xDEADBEEF; bus_err pulse; err_count increments. Repeat with slv_rdy on cycle 255 -> real data returned, no error.
- Reset asserted in the middle of an ACCESS stall -> slv_op, cpu_mem_rdy and err_count are 0 immediately (asynchronous); after release, the next read completes normally.
- 65536 unmapped accesses followed by one more -> err_count stays 0xFFFF.
